// File: rtl/tile_scanout.sv
// Streams an 8x8 tile buffer out as a valid/ready pixel stream with absolute screen
// coordinates; a 3-entry FIFO absorbs the buffer read latency and downstream stalls.
module tile_scanout #(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7,
    parameter int PIX_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [COL_BITS-1:0] tile_col,
    input  logic [ROW_BITS-1:0] tile_row,
    output logic                busy,
    output logic                done,
    output logic [2:0]          rd_y,
    output logic [2:0]          rd_x,
    output logic                rd_en,
    input  logic [PIX_W-1:0]    rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    out_pix,
    output logic [COL_BITS+2:0] out_x,
    output logic [ROW_BITS+2:0] out_y,
    output logic                out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_e;

    state_e              state_q;
    logic [5:0]          idx_q;
    logic [5:0]          addr_q;
    logic [COL_BITS-1:0] col_q;
    logic [ROW_BITS-1:0] row_q;
    logic                busy_q;
    logic                done_q;
    logic                inflight_q;

    logic [PIX_W-1:0]    pix_mem [3];
    logic [5:0]          yx_mem  [3];
    logic [1:0]          wr_ptr_q;
    logic [1:0]          rd_ptr_q;
    logic [1:0]          count_q;

    logic                push;
    logic                pop;
    logic                head_last;
    logic [5:0]          head_yx;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when a FIFO slot is guaranteed for its data next cycle.
    assign rd_en     = (state_q == S_READ) &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2);
    assign push      = inflight_q;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign head_yx   = yx_mem[rd_ptr_q];
    assign head_last = out_valid && (head_yx == 6'h3F);

    assign rd_y      = rd_en ? idx_q[5:3] : addr_q[5:3];
    assign rd_x      = rd_en ? idx_q[2:0] : addr_q[2:0];
    assign busy      = busy_q;
    assign done      = done_q;

    assign out_pix   = out_valid ? pix_mem[rd_ptr_q] : '0;
    assign out_x     = out_valid ? {col_q, head_yx[2:0]} : '0;
    assign out_y     = out_valid ? {row_q, head_yx[5:3]} : '0;
    assign out_last  = head_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        col_q   <= tile_col;
                        row_q   <= tile_row;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        addr_q <= idx_q;
                        idx_q  <= idx_q + 6'd1;
                        if (idx_q == 6'd63) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= rd_en;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the stream outputs are masked while empty, so
    // stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            pix_mem[wr_ptr_q] <= rd_data;
            yx_mem[wr_ptr_q]  <= addr_q;
        end
    end

endmodule

// File: tb/tb_tile_scanout.sv
// Directed bench for tile_scanout: models the registered tile buffer, scoreboards the
// pixel stream against raster order, and checks latency, backpressure and reset cases.
module tb_tile_scanout;

    localparam int COL_BITS = 7;
    localparam int ROW_BITS = 7;
    localparam int PIX_W    = 24;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [COL_BITS-1:0] tile_col = '0;
    logic [ROW_BITS-1:0] tile_row = '0;
    logic                busy;
    logic                done;
    logic [2:0]          rd_y;
    logic [2:0]          rd_x;
    logic                rd_en;
    logic [PIX_W-1:0]    rd_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [PIX_W-1:0]    out_pix;
    logic [COL_BITS+2:0] out_x;
    logic [ROW_BITS+2:0] out_y;
    logic                out_last;

    tile_scanout #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tile_col(tile_col), .tile_row(tile_row),
        .busy(busy), .done(done), .rd_y(rd_y), .rd_x(rd_x), .rd_en(rd_en),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PIX_W-1:0] tile_mem [64];
    always @(posedge clk) if (rd_en) rd_data <= tile_mem[{rd_y, rd_x}];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard / occupancy model state
    bit                  mon_en = 1'b0;
    bit                  rand_ready = 1'b0;
    int                  start_cyc = 0;
    int                  exp_idx, hs_count, rd_count, first_valid, last_hs, occ, max_occ;
    bit                  push_pend, pop_pend, inflight_m, stall_prev;
    logic [PIX_W-1:0]    stall_pix;
    logic [PIX_W-1:0]    pix_base;
    logic [COL_BITS-1:0] exp_col;
    logic [ROW_BITS-1:0] exp_row;

    always @(negedge clk) begin
        if (mon_en) begin
            occ        = occ + int'(push_pend) - int'(pop_pend);
            push_pend  = inflight_m;
            inflight_m = rd_en;
            if (occ > max_occ) max_occ = occ;
            check("valid_vs_occupancy", out_valid, occ != 0);
            if (rd_en) rd_count++;
            if (out_valid && first_valid < 0) first_valid = cyc - start_cyc;
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_pix", out_pix, stall_pix);
            end
            stall_prev = out_valid && !out_ready;
            stall_pix  = out_pix;
            pop_pend   = out_valid && out_ready;
            if (pop_pend) begin
                check("hs_in_range", exp_idx < 64, 1);
                check("pix", out_pix, PIX_W'(pix_base + PIX_W'(exp_idx)));
                check("out_x", out_x, int'(exp_col) * 8 + exp_idx % 8);
                check("out_y", out_y, int'(exp_row) * 8 + exp_idx / 8);
                check("out_last", out_last, exp_idx == 63);
                exp_idx++;
                hs_count++;
                last_hs = cyc - start_cyc;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic load_tile(input logic [PIX_W-1:0] base);
        pix_base = base;
        for (int i = 0; i < 64; i++) tile_mem[i] = PIX_W'(base + PIX_W'(i));
    endtask

    task automatic clear_model();
        occ = 0; push_pend = 0; pop_pend = 0; inflight_m = 0; stall_prev = 0;
    endtask

    // Drives start during the current cycle (cycle 0 of the scan)
    task automatic begin_scan(input logic [COL_BITS-1:0] col, input logic [ROW_BITS-1:0] row);
        start = 1'b1; tile_col = col; tile_row = row;
        start_cyc = cyc; exp_col = col; exp_row = row;
        exp_idx = 0; hs_count = 0; rd_count = 0; first_valid = -1; last_hs = -1; max_occ = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_scan(input logic [COL_BITS-1:0] col, input logic [ROW_BITS-1:0] row);
        @(posedge clk); #1;
        begin_scan(col, row);
    endtask

    task automatic wait_cycle(input int k);
        while (cyc - start_cyc < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc - start_cyc;
                break;
            end
        end
        check("done_seen", dcyc >= 0, 1);
        if (dcyc >= 0) check("busy_low_at_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int d;
    int hs_a;

    initial begin
        load_tile(24'h000000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_en", rd_en, 0);
        rst_n = 1'b1;
        clear_model();
        mon_en = 1'b1;

        // Full-rate scan, pix = {y,x}, tile (col 5, row 2)
        start_scan(7'd5, 7'd2);
        check("c1_busy", busy, 1);
        check("c1_rd_en", rd_en, 1);
        check("c1_rd_y", rd_y, 0);
        check("c1_rd_x", rd_x, 0);
        wait_done(200, d);
        check("t1_done_cycle", d, 67);
        check("t1_first_valid", first_valid, 3);
        check("t1_last_hs_cycle", last_hs, 66);
        check("t1_hs_count", hs_count, 64);
        check("t1_reads", rd_count, 64);
        @(negedge clk);
        check("t1_done_pulse_1cyc", done, 0);

        // Backpressure: out_ready low for cycles 2..11
        load_tile(24'h5A0000);
        start_scan(7'd9, 7'd4);
        wait_cycle(2);
        out_ready = 1'b0;
        wait_cycle(11);
        @(negedge clk);
        check("bp_reads", rd_count, 3);
        check("bp_rd_en_off", rd_en, 0);
        check("bp_rd_y_hold", rd_y, 0);
        check("bp_rd_x_hold", rd_x, 2);
        check("bp_valid", out_valid, 1);
        check("bp_head_pix", out_pix, 24'h5A0000);
        check("bp_fifo_full", max_occ, 3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(300, d);
        check("bp_hs_count", hs_count, 64);

        // Random backpressure
        load_tile(24'h123400);
        start_scan(7'd0, 7'd127);
        rand_ready = 1'b1;
        wait_done(2000, d);
        rand_ready = 1'b0;
        #2 out_ready = 1'b1;
        check("rnd_hs_count", hs_count, 64);
        check("rnd_max_occ_le3", max_occ <= 3, 1);
        check("rnd_reads", rd_count, 64);

        // Spurious start mid-scan must be ignored
        load_tile(24'hABC000);
        start_scan(7'd17, 7'd33);
        wait_cycle(20);
        start = 1'b1; tile_col = 7'd1; tile_row = 7'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, d);
        check("rs_done_cycle", d, 67);
        check("rs_hs_count", hs_count, 64);

        // Asynchronous reset mid-scan
        load_tile(24'h777700);
        start_scan(7'd3, 7'd6);
        wait_cycle(30);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_rd_en", rd_en, 0);
        check("mr_done", done, 0);
        check("mr_rd_y", rd_y, 0);
        check("mr_rd_x", rd_x, 0);
        check("mr_out_pix", out_pix, 0);
        check("mr_out_x", out_x, 0);
        check("mr_out_y", out_y, 0);
        check("mr_out_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        mon_en = 1'b1;
        load_tile(24'hF00F00);
        start_scan(7'd64, 7'd8);
        wait_done(200, d);
        check("mr_rescan_done_cycle", d, 67);
        check("mr_rescan_hs_count", hs_count, 64);

        // Back-to-back: second start during the done cycle
        load_tile(24'h0C0C00);
        start_scan(7'd127, 7'd127);
        wait_done(200, d);
        hs_a = hs_count;
        check("b2b_a_done_cycle", d, 67);
        check("b2b_a_hs_count", hs_a, 64);
        begin_scan(7'd0, 7'd1);
        wait_done(200, d);
        check("b2b_b_first_valid", first_valid, 3);
        check("b2b_b_done_cycle", d, 67);
        check("b2b_b_hs_count", hs_count, 64);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_scanout.md
# tile_scanout

Streams the 64 pixels of an 8x8 tile buffer out to the framebuffer write path. Sits directly downstream of the tile buffer: it drives the buffer's read address and read enable, absorbs the buffer's one-cycle registered read latency, and presents pixels on a valid/ready stream. Each pixel carries its absolute screen coordinates, derived from the tile position latched at start. A 3-entry output FIFO allows full-rate streaming under backpressure without losing pixels.

## Interface
- COL_BITS, default 7: width of the tile column index.
- ROW_BITS, default 7: width of the tile row index.
- PIX_W, default 24: pixel width; must equal the tile buffer data width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a scanout; sampled only in IDLE
- tile_col  in  COL_BITS  tile column index; latched on accepted start
- tile_row  in  ROW_BITS  tile row index; latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last pixel handshake
- rd_y  out  3  tile buffer read row
- rd_x  out  3  tile buffer read column
- rd_en  out  1  tile buffer read enable
- rd_data  in  PIX_W  tile buffer registered read data, valid the cycle after rd_en
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_pix  out  PIX_W  pixel value
- out_x  out  COL_BITS+3  screen x = {tile_col, x}
- out_y  out  ROW_BITS+3  screen y = {tile_row, y}
- out_last  out  1  high with pixel (7,7)

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: start=1 latches tile_col/tile_row, clears the 6-bit read index, and moves to READ. start in READ or DRAIN is ignored.
- READ: rd_en=1 only when FIFO occupancy + in-flight read <= 2. When rd_en=1, rd_y = index[5:3] and rd_x = index[2:0], and the index increments. Order is raster with x fastest: (0,0),(0,1)..(0,7),(1,0)..(7,7).
- READ to DRAIN: after the read of index 63 is issued.
- In-flight flag: register set when rd_en=1. The cycle after, rd_data is pushed into the FIFO together with its y/x.
- FIFO: 3 entries. Each entry holds pix, y, x. out_valid = FIFO non-empty. A pop occurs on out_valid && out_ready. Push and pop in the same cycle leave occupancy unchanged. Overflow is impossible by construction; the bench asserts occupancy never exceeds 3.
- out_last = (head y == 7 && head x == 7).
- DRAIN: no reads. When the pixel with out_last is accepted, done=1 for that next cycle, busy=0, and the state returns to IDLE.
- rd_y/rd_x hold their last value when rd_en=0. rd_en is never high outside READ.
- Reset (any time, including mid-scan): state IDLE, index 0, in-flight flag cleared, FIFO emptied.
- Reset values: busy=0, done=0, rd_en=0, rd_y=0, rd_x=0, out_valid=0, out_last=0, out_pix=0, out_x=0, out_y=0.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycle 1: busy=1, rd_en=1, address (0,0).
- Cycle 2: rd_data holds pixel (0,0) and is pushed.
- Cycle 3: out_valid=1 with pixel (0,0). Start to first valid is 3 cycles.
- With out_ready held high, one pixel is accepted per cycle in cycles 3..66 with no bubbles. done=1 and busy=0 in cycle 67.
- A new start is accepted in cycle 67 (the done cycle).
- While out_ready=0: at most 3 pixels are buffered and reads stop. Stream outputs stay stable while valid && !ready.
- Tile data must not be rewritten during busy; pixels read later reflect the buffer contents at their read cycle.

## Test plan
- Tile preloaded with pix = {y,x} pattern, tile_col=5, tile_row=2, out_ready=1 -> 64 pixels in cycles 3..66. First pixel has out_x=40, out_y=16. Last has out_x=47, out_y=23, out_last=1. done in cycle 67.
- out_ready held low from cycle 2 for 10 cycles -> exactly 3 reads issued, FIFO full, out_pix stable at pixel (0,0). After release, the stream continues in order with no loss or duplicates.
- Random out_ready at 50% -> all 64 pixels in raster order, each exactly once. out_last is high only on (7,7). FIFO occupancy never exceeds 3.
- start pulsed again at cycle 20 of a scan -> ignored. Latched tile_col/tile_row remain unchanged and exactly 64 pixels are produced.
- rst_n low at cycle 30 -> same cycle: out_valid=0, busy=0, rd_en=0. After release, a new start produces a full correct 64-pixel scan.
- Back-to-back: second start in the done cycle -> second scan's first out_valid appears 3 cycles later.
